// File: rtl/pet_needs_core.sv
// Pet needs core: NUM_NEEDS decaying need levels plus the pet mood/activity FSM (optional PET_AUTO_SLEEP_EN).
// Latency: levels update on the edge ending a tick cycle; state and low_led follow the levels one cycle later.
// Backpressure: none; action/wake pulses are accepted or ignored by state, never stalled.
module pet_needs_core #(
    parameter int NUM_NEEDS   = 3,
    parameter int LEVEL_W     = 3,
    parameter int TICK_DIV    = 50000000,
    parameter int DECAY_TICKS = 10,
    parameter int LOW_TH      = 2,
    parameter int REFILL      = 3,
    parameter int ACT_TICKS   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_NEEDS-1:0]           action,
    input  logic                           btn_awake,
    input  logic                           giro,
    input  logic                           test_mode,
    input  logic                           test_step,
    output logic [3:0]                     state,
    output logic [NUM_NEEDS*LEVEL_W-1:0]   levels,
    output logic [NUM_NEEDS-1:0]           low_led,
    output logic                           tick
);

    localparam logic [LEVEL_W-1:0] MAX = '1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int AW = (ACT_TICKS > 1) ? $clog2(ACT_TICKS) : 1;

    typedef enum logic [3:0] {
        HAPPY = 4'd0,
        NEEDY = 4'd1,
        SLEEP = 4'd2,
        SICK  = 4'd5,
        ACT   = 4'd8
    } mode_t;

    mode_t              mode_q, mode_d, cls;
    logic [2:0]         need_q, need_d;
    logic [AW-1:0]      act_cnt_q, act_cnt_d;
    logic               refill_vld;
    logic               act_any;
    logic [2:0]         act_idx;
    logic               any_zero, any_low;
    logic [PW-1:0]      pre_cnt;
    logic [LEVEL_W-1:0] lvl [NUM_NEEDS];

    function automatic logic [LEVEL_W-1:0] refill_add(input logic [LEVEL_W-1:0] lv);
        int s;
        s = int'(lv) + REFILL;
        if (s > int'(MAX)) s = int'(MAX);
        return LEVEL_W'(s);
    endfunction

    function automatic logic is_low(input logic [LEVEL_W-1:0] lv);
        return int'(lv) <= LOW_TH;
    endfunction

    // Prescaler holds its count in test mode so leaving test mode resumes the same phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (test_mode) begin
            tick <= test_step;
        end else begin
            tick    <= (pre_cnt == PW'(TICK_DIV - 1));
            pre_cnt <= (pre_cnt == PW'(TICK_DIV - 1)) ? '0 : pre_cnt + PW'(1);
        end
    end

    always_comb begin
        any_zero = 1'b0;
        any_low  = 1'b0;
        for (int k = 0; k < NUM_NEEDS; k++) begin
            if (lvl[k] == '0) any_zero = 1'b1;
            if (is_low(lvl[k])) any_low = 1'b1;
        end
        if (any_zero)     cls = SICK;
        else if (any_low) cls = NEEDY;
        else              cls = HAPPY;
    end

    // Lowest-numbered care action wins when several arrive together.
    always_comb begin
        act_any = 1'b0;
        act_idx = '0;
        for (int k = NUM_NEEDS - 1; k >= 1; k--) begin
            if (action[k]) begin
                act_any = 1'b1;
                act_idx = 3'(k);
            end
        end
    end

    always_comb begin
        mode_d     = mode_q;
        need_d     = need_q;
        act_cnt_d  = act_cnt_q;
        refill_vld = 1'b0;
        case (mode_q)
            ACT: begin
                if (tick) begin
                    if (act_cnt_q == AW'(ACT_TICKS - 1)) mode_d = cls;
                    else                                  act_cnt_d = act_cnt_q + AW'(1);
                end
            end
            SLEEP: begin
                if (btn_awake || giro || lvl[0] == MAX) mode_d = cls;
            end
            default: begin
                if (action[0]) begin
                    mode_d = SLEEP;
                end else if (act_any) begin
                    mode_d     = ACT;
                    need_d     = act_idx;
                    act_cnt_d  = '0;
                    refill_vld = 1'b1;
                end
`ifdef PET_AUTO_SLEEP_EN
                else if (lvl[0] == '0) begin
                    mode_d = SLEEP;
                end
`endif
                else begin
                    mode_d = cls;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= HAPPY;
            need_q    <= '0;
            act_cnt_q <= '0;
        end else begin
            mode_q    <= mode_d;
            need_q    <= need_d;
            act_cnt_q <= act_cnt_d;
        end
    end

    assign state = (mode_q == ACT) ? (4'd8 + {1'b0, need_q}) : mode_q;

    for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_need
        logic [LEVEL_W-1:0] lvl_q;
        logic [LEVEL_W-1:0] step_lvl;
        logic [DW-1:0]      dcnt_q;
        logic               low_q;
        logic               held, wrap, refill_here;

        assign held        = (mode_q == ACT) && (need_q == 3'(g));
        assign wrap        = tick && !held && (dcnt_q == DW'(DECAY_TICKS - 1));
        assign refill_here = refill_vld && (act_idx == 3'(g));

        // Energy recovers while asleep; every other case decays.
        always_comb begin
            step_lvl = lvl_q;
            if (g == 0 && mode_q == SLEEP) begin
                if (lvl_q != MAX) step_lvl = lvl_q + LEVEL_W'(1);
            end else if (lvl_q != '0) begin
                step_lvl = lvl_q - LEVEL_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lvl_q  <= MAX;
                dcnt_q <= '0;
                low_q  <= 1'b0;
            end else begin
                if (tick && !held) dcnt_q <= wrap ? '0 : dcnt_q + DW'(1);
                if (refill_here) lvl_q <= refill_add(lvl_q);
                else if (wrap)   lvl_q <= step_lvl;
                low_q <= is_low(lvl_q);
            end
        end

        assign lvl[g]                         = lvl_q;
        assign levels[g*LEVEL_W +: LEVEL_W]   = lvl_q;
        assign low_led[g]                     = low_q;
    end

endmodule

// File: tb/tb_pet_needs_core.sv
// Testbench for pet_needs_core: directed scenarios plus random pulses against a cycle-level behavioural model.
// Honours PET_AUTO_SLEEP_EN the same way as the design build.
module tb_pet_needs_core;

    localparam int NN = 3, LW = 3, MAXL = 7, TD = 4, DT = 2, LT = 2, RF = 3, AT = 2;
`ifdef PET_AUTO_SLEEP_EN
    localparam int EXP_ALL0 = 2;
`else
    localparam int EXP_ALL0 = 5;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NN-1:0] action = '0;
    logic          btn_awake = 1'b0, giro = 1'b0, test_mode = 1'b0, test_step = 1'b0;
    logic [3:0]    state;
    logic [NN*LW-1:0] levels;
    logic [NN-1:0] low_led;
    logic          tick;

    int n_vec = 0;
    int n_err = 0;

    // Model state, in plain integers.
    int m_lvl[NN];
    int m_dc[NN];
    int m_state, m_act, m_pre, m_tick;
    bit [NN-1:0] m_low;

    pet_needs_core #(
        .NUM_NEEDS(NN), .LEVEL_W(LW), .TICK_DIV(TD), .DECAY_TICKS(DT),
        .LOW_TH(LT), .REFILL(RF), .ACT_TICKS(AT)
    ) dut (
        .clk(clk), .rst(rst), .action(action), .btn_awake(btn_awake), .giro(giro),
        .test_mode(test_mode), .test_step(test_step), .state(state), .levels(levels),
        .low_led(low_led), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int k = 0; k < NN; k++) begin
            m_lvl[k] = MAXL;
            m_dc[k]  = 0;
        end
        m_state = 0; m_act = 0; m_pre = 0; m_tick = 0; m_low = '0;
    endfunction

    function automatic int m_class();
        bit z, l;
        z = 0; l = 0;
        for (int k = 0; k < NN; k++) begin
            if (m_lvl[k] == 0)  z = 1;
            if (m_lvl[k] <= LT) l = 1;
        end
        return z ? 5 : (l ? 1 : 0);
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    function automatic void model_next();
        int nl[NN];
        int nd[NN];
        int ns, na, cls, kref;
        cls = m_class(); ns = m_state; na = m_act; kref = -1;
        for (int k = 0; k < NN; k++) begin
            nl[k] = m_lvl[k];
            nd[k] = m_dc[k];
        end
        if (m_state >= 8) begin
            if (m_tick != 0) begin
                if (m_act + 1 == AT) ns = cls;
                else                 na = m_act + 1;
            end
        end else if (m_state == 2) begin
            if (btn_awake || giro || m_lvl[0] == MAXL) ns = cls;
        end else if (action[0]) begin
            ns = 2;
        end else if (action[NN-1:1] != 0) begin
            for (int k = NN - 1; k >= 1; k--) if (action[k]) kref = k;
            ns = 8 + kref;
            na = 0;
        end else begin
            ns = cls;
`ifdef PET_AUTO_SLEEP_EN
            if (m_lvl[0] == 0) ns = 2;
`endif
        end
        for (int k = 0; k < NN; k++) begin
            if (m_tick != 0 && m_state != 8 + k) begin
                nd[k] = (m_dc[k] + 1) % DT;
                if (m_dc[k] == DT - 1) begin
                    if (k == 0 && m_state == 2) nl[k] = (m_lvl[k] < MAXL) ? m_lvl[k] + 1 : MAXL;
                    else                        nl[k] = (m_lvl[k] > 0) ? m_lvl[k] - 1 : 0;
                end
            end
            if (k == kref) nl[k] = (m_lvl[k] + RF > MAXL) ? MAXL : m_lvl[k] + RF;
            m_low[k] = (m_lvl[k] <= LT);
        end
        if (test_mode) begin
            m_tick = test_step ? 1 : 0;
        end else begin
            m_tick = (m_pre == TD - 1) ? 1 : 0;
            m_pre  = (m_pre + 1) % TD;
        end
        for (int k = 0; k < NN; k++) begin
            m_lvl[k] = nl[k];
            m_dc[k]  = nd[k];
        end
        m_state = ns;
        m_act   = na;
    endfunction

    function automatic logic [16:0] exp_vec();
        return {4'(m_state), 3'(m_lvl[2]), 3'(m_lvl[1]), 3'(m_lvl[0]), m_low, 1'(m_tick)};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {state, levels, low_led, tick};
    endfunction

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
    endtask

    // Step until n model ticks have been seen, then one more edge so their level update is visible.
    task automatic run_ticks(input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < 400 && seen < n; c++) begin
            step();
            if (m_tick != 0) seen++;
        end
        step();
    endtask

    task automatic do_reset();
        action = '0; btn_awake = 0; giro = 0; test_mode = 0; test_step = 0;
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs_vec() !== {4'd0, 9'o777, 3'b000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got %h want %h", obs_vec(), {4'd0, 9'o777, 3'b000, 1'b0});
        end
        rst = 1'b1;
    endtask

    task automatic test_tick_period();
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++;
            if (tick !== ((i % 4) == 3)) begin
                n_err++;
                $display("FAIL tick_period cycle=%0d got %b want %b", i, tick, (i % 4) == 3);
            end
        end
        step();
        n_vec++;
        if ({state, levels} !== {4'd0, 9'o666}) begin
            n_err++;
            $display("FAIL two_ticks got state=%0d levels=%o want state=0 levels=666", state, levels);
        end
    endtask

    task automatic test_decay();
        run_ticks(8);
        n_vec++;
        if (levels !== 9'o222) begin
            n_err++;
            $display("FAIL decay10 got levels=%o want 222", levels);
        end
        step();
        n_vec++;
        if (state !== 4'd1) begin
            n_err++;
            $display("FAIL needy got state=%0d want 1", state);
        end
        run_ticks(4);
        n_vec++;
        if (levels !== 9'o000) begin
            n_err++;
            $display("FAIL decay14 got levels=%o want 000", levels);
        end
        step();
        n_vec++;
        if (state !== 4'(EXP_ALL0)) begin
            n_err++;
            $display("FAIL all_zero_state got %0d want %0d", state, EXP_ALL0);
        end
    endtask

    task automatic test_care();
        do_reset();
        run_ticks(4);
        n_vec++;
        if ({state, levels} !== {4'd0, 9'o555}) begin
            n_err++;
            $display("FAIL care_setup got state=%0d levels=%o want 0/555", state, levels);
        end
        action = 3'b010;
        step();
        action = '0;
        n_vec++;
        if ({state, levels} !== {4'd9, 9'o575}) begin
            n_err++;
            $display("FAIL care_enter got state=%0d levels=%o want 9/575", state, levels);
        end
        for (int c = 0; c < 100 && m_state == 9; c++) begin
            step();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL care_trace got %h want %h", obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if ({state, levels} !== {4'd0, 9'o474}) begin
            n_err++;
            $display("FAIL care_exit got state=%0d levels=%o want 0/474", state, levels);
        end
    endtask

    task automatic test_sleep();
        int e0, l2;
        e0 = m_lvl[0];
        l2 = m_lvl[2];
        action = 3'b101;
        step();
        action = '0;
        n_vec++;
        if ({state, levels[8:6]} !== {4'd2, 3'(l2)}) begin
            n_err++;
            $display("FAIL sleep_enter got state=%0d lvl2=%0d want 2/%0d", state, levels[8:6], l2);
        end
        run_ticks(4);
        n_vec++;
        if ({state, levels[2:0]} !== {4'd2, 3'(e0 + 2)}) begin
            n_err++;
            $display("FAIL sleep_recover got state=%0d energy=%0d want 2/%0d", state, levels[2:0], e0 + 2);
        end
        giro = 1'b1;
        step();
        giro = 1'b0;
        n_vec++;
        if (state === 4'd2 || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL giro_wake got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_test_mode();
        logic [8:0] snap;
        test_mode = 1'b1;
        step();
        snap = {3'(m_lvl[2]), 3'(m_lvl[1]), 3'(m_lvl[0])};
        for (int c = 0; c < 20; c++) begin
            step();
            n_vec++;
            if ({tick, levels} !== {1'b0, snap}) begin
                n_err++;
                $display("FAIL frozen c=%0d got tick=%b levels=%o want 0/%o", c, tick, levels, snap);
            end
        end
        for (int p = 0; p < 2; p++) begin
            test_step = 1'b1;
            step();
            test_step = 1'b0;
            step();
            step();
        end
        n_vec++;
        if (levels !== {snap[8:6] - 3'd1, snap[5:3] - 3'd1, snap[2:0] - 3'd1}) begin
            n_err++;
            $display("FAIL test_step got levels=%o from %o want each -1", levels, snap);
        end
        test_mode = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            action    = '0;
            if ($urandom_range(0, 9) == 0) action = 3'($urandom_range(1, 7));
            btn_awake = ($urandom_range(0, 19) == 0);
            giro      = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) test_mode = ~test_mode;
            test_step = test_mode && ($urandom_range(0, 2) == 0);
            step();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random i=%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        action = '0; btn_awake = 0; giro = 0; test_mode = 0; test_step = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        run_ticks(4);
        action = 3'b010;
        step();
        action = '0;
        n_vec++;
        if (state !== 4'd9) begin
            n_err++;
            $display("FAIL act_before_reset got state=%0d want 9", state);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (obs_vec() !== {4'd0, 9'o777, 3'b000, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset got %h want %h", obs_vec(), {4'd0, 9'o777, 3'b000, 1'b0});
        end
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL post_reset c=%0d got %h want %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick_period();
        test_decay();
        test_care();
        test_sleep();
        test_test_mode();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pet_needs_core.md
Name: pet_needs_core

Overview:
Parametrised successor to the fixed three-need pet controller. It keeps NUM_NEEDS need levels (index 0 is always energy), decays them on a prescaled time tick, refills them on action pulses, and runs the pet mood/activity state machine. It sits between the button debouncers and the display blocks (seven-segment decoder, LCD, LEDs). A test mode replaces the prescaler with single-step ticks.

Parameters:
NUM_NEEDS, 3, number of need channels (2..8); index 0 = energy.
LEVEL_W, 3, bits per need level; MAX = 2^LEVEL_W-1.
TICK_DIV, 50000000, clk cycles per time tick (>=2).
DECAY_TICKS, 10, ticks between successive decay/recover steps of one need (>=1).
LOW_TH, 2, a level <= LOW_TH counts as low.
REFILL, 3, amount added to a need by its action; saturates at MAX.
ACT_TICKS, 2, ticks an action state lasts (>=1).

Ports:
clk  in  1  system clock
rst  in  1  reset: asynchronous, active-low
action  in  NUM_NEEDS  1-cycle debounced pulses; bit0 = sleep request, bit k = care action for need k
btn_awake  in  1  1-cycle wake pulse
giro  in  1  1-cycle shake pulse; acts as wake
test_mode  in  1  1 = prescaler frozen, ticks come from test_step
test_step  in  1  1-cycle pulse; one tick when test_mode=1
state  out  4  0 HAPPY, 1 NEEDY, 2 SLEEP, 5 SICK, 8+k ACT on need k
levels  out  NUM_NEEDS*LEVEL_W  packed levels; need k at [k*LEVEL_W +: LEVEL_W]
low_led  out  NUM_NEEDS  bit k = 1 when level k <= LOW_TH
tick  out  1  registered 1-cycle pulse per time tick

Behaviour:
- Reset (rst=0, async): all levels = MAX; state = HAPPY; prescaler, decay counters and activity counter = 0; tick = 0; low_led = 0.
- Prescaler: when test_mode=0, counts 0..TICK_DIV-1; tick is 1 in the cycle after the count wraps. When test_mode=1, the prescaler holds its value and tick = test_step delayed by one cycle. Toggling test_mode does not clear the prescaler.
- Per-need decay counter: counts ticks 0..DECAY_TICKS-1. On wrap, the level steps: -1 saturating at 0. Exception: need 0 in SLEEP steps +1, saturating at MAX.
- Need k is held (neither counter nor level changes) while state = 8+k.
- Level updates occur in the tick cycle. Mood class is derived combinationally from the levels: SICK if any level = 0; else NEEDY if any level <= LOW_TH; else HAPPY. The state register reflects the class one cycle later.
- In HAPPY, NEEDY or SICK, each cycle is handled in this priority order:
  - action[0]: go to SLEEP.
  - Else, the lowest set action bit k>=1: go to state 8+k. Level k is set to min(level+REFILL, MAX) in the same cycle, and the activity counter is cleared.
  - Else: state follows the class.
- ACT (8+k): the activity counter increments on each tick. After ACT_TICKS ticks the state returns to the class. Action, wake and giro pulses are ignored.
- SLEEP: btn_awake or giro, or energy reaching MAX, leads to the class on the next cycle. Action pulses are ignored.
- If a refill coincides with a decay on the same need, the refill takes effect and the decay step is dropped.
- low_led is registered from the levels and follows them with one cycle of latency.

Optional Feature:
PET_AUTO_SLEEP_EN. When defined: if energy reaches 0 while in HAPPY, NEEDY or SICK, the state goes to SLEEP instead of SICK. This auto-sleep has lower priority than a same-cycle action pulse. When undefined: energy at 0 follows the normal class rule and gives SICK.

Test Plan:
Bench parameters: NUM_NEEDS=3, LEVEL_W=3, TICK_DIV=4, DECAY_TICKS=2, LOW_TH=2, REFILL=3, ACT_TICKS=2.
1. Release reset and run. Required: levels 7/7/7 and state 0 out of reset; tick every 4 cycles; after 2 ticks all levels 6; state 0.
2. Free-run from reset. Required: after 10 ticks levels 2 and state 1 one cycle later; after 14 ticks levels 0 and state 5 (macro off) or state 2 (macro on).
3. With levels 5/5/5 in HAPPY, pulse action[1]. Required: level1 = 7 (saturated), state 9; need 1 frozen for 2 ticks; then state 0.
4. Pulse action[0] and action[2] in the same cycle. Required: state 2, level2 unchanged, energy +1 every 2 ticks. Then pulse giro: state returns to the class next cycle.
5. Set test_mode=1 and wait 20 cycles with no test_step. Required: no tick and levels unchanged. Then send 2 test_step pulses: all non-held levels decrement by 1.
6. Assert rst=0 mid-ACT (state 9). Required: state 0 and levels 7/7/7 immediately, without waiting for a clk edge.
